// File: rtl/ysyx_25040129_rtc_if.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_rtc_if
// Read-only AXI4-Lite bundle between the crossbar RTC port and the RTC.
//   araddr  [31:0] read address            (master -> slave)
//   arvalid        read address valid      (master -> slave)
//   arready        read address ready      (slave  -> master)
//   rdata   [31:0] read data               (slave  -> master)
//   rresp   [1:0]  read response           (slave  -> master)
//   rvalid         read data valid         (slave  -> master)
//   rready         read data ready         (master -> slave)
// ----------------------------------------------------------------------------
interface ysyx_25040129_rtc_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr,
        output arvalid,
        output rready,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid
    );

    modport slave (
        input  araddr,
        input  arvalid,
        input  rready,
        output arready,
        output rdata,
        output rresp,
        output rvalid
    );
endinterface

// File: rtl/ysyx_25040129_rtc.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_rtc
// Read-only AXI4-Lite responder around a free-running 64-bit machine timer.
// Reading offset 0x0 returns mtime[31:0] and snapshots mtime[63:32] into a
// shadow register; offset 0x4 returns that shadow, so two 32-bit reads give
// a tear-free 64-bit value. Every other offset answers SLVERR with zero data.
//
// Parameters
//   DIV       mtime increments once every DIV clocks (DIV >= 1)
//   RESP_LAT  extra wait cycles between address accept and rvalid (0..15)
//   MTIME_RST value mtime takes in reset (0 in normal use)
// Ports
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  slave side of the read-only AXI4-Lite bundle
// ----------------------------------------------------------------------------
module ysyx_25040129_rtc #(
    parameter int          DIV       = 1,
    parameter int          RESP_LAT  = 0,
    parameter logic [63:0] MTIME_RST = 64'd0
) (
    input logic               clk,
    input logic               rst,
    ysyx_25040129_rtc_if.slave bus
);

    // Prescaler needs at least one bit even when DIV is 1.
    localparam int          PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam bit          HAS_WAIT   = (RESP_LAT > 0);
    localparam logic [3:0]  WAIT_LOAD  = HAS_WAIT ? 4'(RESP_LAT - 1) : 4'd0;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [PW-1:0]   presc;
    logic [63:0]     mtime;
    logic [31:0]     shadow_hi;

    logic [3:0]      wait_cnt;
    logic [3:0]      wait_cnt_next;

    logic            arready_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic [1:0]      rresp_q;

    logic            handshake;
    logic            rd_capture;
    logic [1:0]      rd_resp;
    logic [31:0]     rd_data;

    // Upper address bits are decoded by the crossbar, not here.
    logic            unused_addr;
    assign unused_addr = ^bus.araddr[31:4];

    // Register-map decode: returns {capture_shadow, rresp, rdata} for an offset.
    function automatic logic [34:0] decode_read(
        input logic [3:0]  offset,
        input logic [63:0] now,
        input logic [31:0] shadow
    );
        logic [34:0] result;
        case (offset)
            4'h0:    result = {1'b1, RESP_OKAY,   now[31:0]};
            4'h4:    result = {1'b0, RESP_OKAY,   shadow};
            default: result = {1'b0, RESP_SLVERR, 32'd0};
        endcase
        return result;
    endfunction

    // arready_q is high only in IDLE, so it doubles as the accept qualifier.
    assign handshake = arready_q && bus.arvalid;

    // Read-data selection from the current counter and shadow.
    always_comb begin
        {rd_capture, rd_resp, rd_data} = decode_read(bus.araddr[3:0], mtime, shadow_hi);
    end

    // Next-state and wait-counter logic of the read FSM.
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    if (HAS_WAIT) begin
                        next_state    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        next_state    = ST_RESP;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rready) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_RESP;
                end
            end
            default: begin
                next_state    = ST_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // FSM state and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Handshake outputs, registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            arready_q <= (next_state == ST_IDLE);
            rvalid_q  <= (next_state == ST_RESP);
        end
    end

    // Response payload frozen at the address handshake and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
            rresp_q <= RESP_OKAY;
        end else if (handshake) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
        end
    end

    // Shadow of the high word, taken from the same pre-increment mtime as the low word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_hi <= 32'd0;
        end else if (handshake && rd_capture) begin
            shadow_hi <= mtime[63:32];
        end
    end

    // Free-running prescaler and 64-bit timer; wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            mtime <= MTIME_RST;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_25040129_rtc.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25040129_rtc
// Bench for ysyx_25040129_rtc. Three instances share clk/rst:
//   0: DIV=1, RESP_LAT=0
//   1: DIV=4, RESP_LAT=2
//   2: DIV=1, RESP_LAT=0, mtime starting at 0x1_FFFF_FFF6
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. edge_cnt counts rising edges since the last reset release.
// ----------------------------------------------------------------------------
module tb_ysyx_25040129_rtc;

    localparam logic [63:0] C_INIT = 64'h0000_0001_FFFF_FFF6;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        int          hs;
    } exp_t;

    logic clk;
    logic rst;
    int   edge_cnt;
    int   checks;
    int   errors;

    logic [31:0] araddr_d  [3];
    logic        arvalid_d [3];
    logic        rready_d  [3];
    logic        arready_w [3];
    logic        rvalid_w  [3];
    logic [31:0] rdata_w   [3];
    logic [1:0]  rresp_w   [3];

    exp_t exp_q [3][$];
    exp_t cur   [3];
    int   hs_edge  [3];
    bit   in_resp  [3];
    bit   acc_pend [3];
    int   lat_of   [3];

    ysyx_25040129_rtc_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_wire
        assign bus[g].araddr  = araddr_d[g];
        assign bus[g].arvalid = arvalid_d[g];
        assign bus[g].rready  = rready_d[g];
        assign arready_w[g]   = bus[g].arready;
        assign rvalid_w[g]    = bus[g].rvalid;
        assign rdata_w[g]     = bus[g].rdata;
        assign rresp_w[g]     = bus[g].rresp;
    end

    ysyx_25040129_rtc #(.DIV(1), .RESP_LAT(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus[0])
    );

    ysyx_25040129_rtc #(.DIV(4), .RESP_LAT(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus[1])
    );

    ysyx_25040129_rtc #(.DIV(1), .RESP_LAT(0), .MTIME_RST(C_INIT)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic mon(input int i);
        if (acc_pend[i]) begin
            check($sformatf("rvalid_drop[%0d]", i), 64'(rvalid_w[i]), 64'd0);
            check($sformatf("arready_back[%0d]", i), 64'(arready_w[i]), 64'd1);
            acc_pend[i] = 1'b0;
        end
        if (arvalid_d[i] && arready_w[i]) hs_edge[i] = edge_cnt + 1;
        if (rvalid_w[i]) begin
            if (!in_resp[i]) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid[%0d] actual=1 required=0", i);
                end else begin
                    cur[i]     = exp_q[i].pop_front();
                    in_resp[i] = 1'b1;
                    check($sformatf("hs_edge[%0d]", i), 64'(hs_edge[i]), 64'(cur[i].hs));
                    check($sformatf("latency[%0d]", i), 64'(edge_cnt - hs_edge[i]), 64'(lat_of[i]));
                end
            end
            if (in_resp[i]) begin
                check($sformatf("rdata[%0d]", i), 64'(rdata_w[i]), 64'(cur[i].data));
                check($sformatf("rresp[%0d]", i), 64'(rresp_w[i]), 64'(cur[i].resp));
                check($sformatf("arready_busy[%0d]", i), 64'(arready_w[i]), 64'd0);
                if (rready_d[i]) begin
                    in_resp[i]  = 1'b0;
                    acc_pend[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    in_resp[i]  = 1'b0;
                    acc_pend[i] = 1'b0;
                    exp_q[i].delete();
                end
            end else begin
                for (int i = 0; i < 3; i++) mon(i);
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] addr, input int hs,
                         input logic [31:0] data, input logic [1:0] resp, input int bp);
        exp_t e;
        int   guard;
        if (edge_cnt > hs - 1) begin
            checks++;
            errors++;
            $display("FAIL late_issue[%0d] actual=%0d required=%0d", i, edge_cnt, hs - 1);
        end
        guard = 0;
        while (edge_cnt < hs - 1 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        e.data = data;
        e.resp = resp;
        e.hs   = hs;
        exp_q[i].push_back(e);
        arvalid_d[i] = 1'b1;
        araddr_d[i]  = addr;
        @(posedge clk); #1;
        arvalid_d[i] = 1'b0;
        araddr_d[i]  = 32'h0;
        guard = 0;
        while (!rvalid_w[i] && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rvalid_w[i]) begin
            checks++;
            errors++;
            $display("FAIL rvalid_timeout[%0d] actual=0 required=1", i);
            if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
            return;
        end
        repeat (bp) begin
            @(posedge clk); #1;
        end
        rready_d[i] = 1'b1;
        @(posedge clk); #1;
        rready_d[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_arready[%0d]", tag, i), 64'(arready_w[i]), 64'd0);
            check($sformatf("%s_rvalid[%0d]", tag, i),  64'(rvalid_w[i]),  64'd0);
            check($sformatf("%s_rdata[%0d]", tag, i),   64'(rdata_w[i]),   64'd0);
            check($sformatf("%s_rresp[%0d]", tag, i),   64'(rresp_w[i]),   64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        lat_of[0] = 0;
        lat_of[1] = 2;
        lat_of[2] = 0;
        for (int i = 0; i < 3; i++) begin
            araddr_d[i]  = 32'h0;
            arvalid_d[i] = 1'b0;
            rready_d[i]  = 1'b0;
            hs_edge[i]   = 0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_mtime_a", dut_a.mtime, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        fork
            begin
                issue(0, 32'h0000_0000, 10, 32'h0000_0009, 2'b00, 0);
                issue(0, 32'h0000_0004, 12, 32'h0000_0000, 2'b00, 0);
                issue(0, 32'h8000_0000, 20, 32'h0000_0013, 2'b00, 5);
                issue(0, 32'h0000_0008, 40, 32'h0000_0000, 2'b10, 0);
                issue(0, 32'h0000_0002, 50, 32'h0000_0000, 2'b10, 0);
                issue(0, 32'h0000_000C, 55, 32'h0000_0000, 2'b10, 2);
                issue(0, 32'h0000_0004, 60, 32'h0000_0000, 2'b00, 0);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    check($sformatf("mtime_b_edge%0d", k), dut_b.mtime, (k == 4) ? 64'd1 : 64'd0);
                    @(posedge clk); #1;
                end
                issue(1, 32'h0000_0000,  8, 32'h0000_0001, 2'b00, 0);
                issue(1, 32'h0000_0000, 12, 32'h0000_0002, 2'b00, 0);
                issue(1, 32'h0000_0000, 17, 32'h0000_0004, 2'b00, 3);
                issue(1, 32'h0000_0004, 26, 32'h0000_0000, 2'b00, 0);
                issue(1, 32'h0000_000A, 32, 32'h0000_0000, 2'b10, 0);
            end
            begin
                issue(2, 32'h0000_0000,  10, 32'hFFFF_FFFF, 2'b00, 0);
                issue(2, 32'h0000_0004,  60, 32'h0000_0001, 2'b00, 0);
                issue(2, 32'h0000_0008,  70, 32'h0000_0000, 2'b10, 0);
                issue(2, 32'h0000_0002,  80, 32'h0000_0000, 2'b10, 0);
                issue(2, 32'h0000_0004,  90, 32'h0000_0001, 2'b00, 0);
                issue(2, 32'h0000_0000, 100, 32'h0000_0059, 2'b00, 0);
                issue(2, 32'h0000_0004, 110, 32'h0000_0002, 2'b00, 0);
            end
        join

        // Read left pending under backpressure, then reset mid-response.
        begin
            exp_t e;
            while (edge_cnt < 119) begin
                @(posedge clk); #1;
            end
            e.data = 32'h0000_0077;
            e.resp = 2'b00;
            e.hs   = 120;
            exp_q[0].push_back(e);
            arvalid_d[0] = 1'b1;
            araddr_d[0]  = 32'h0;
            @(posedge clk); #1;
            arvalid_d[0] = 1'b0;
            @(posedge clk); #1;
            check("pre_rst_rvalid", 64'(rvalid_w[0]), 64'd1);
            rst = 1'b1;
            #1;
            check_reset_outputs("async_rst");
            repeat (2) begin
                @(posedge clk); #1;
            end
            check("rst_hold_mtime_a", dut_a.mtime, 64'd0);
            rst = 1'b0;
        end

        fork
            issue(0, 32'h0000_0000, 3, 32'h0000_0002, 2'b00, 0);
            issue(2, 32'h0000_0004, 3, 32'h0000_0000, 2'b00, 0);
        join
        issue(2, 32'h0000_0000, 6, 32'hFFFF_FFFB, 2'b00, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("queue_empty[%0d]", i), 64'(exp_q[i].size()), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
